fsm_cc7_sched: RTL and testbench

- Round-robin scheduler that shares one fsm_cc7_2 step sequencer between N_REQ requesters.
- Drives the sequencer's go and jmp inputs, so each granted requester gets one pass S0 -> S3 (held for a programmable dwell) -> S4..S9 -> S0.
- Monitors the sequencer's y1 output to confirm the sequencer is tracking, and flags loss of sync.
- Sits beside fsm_cc7_2 in the FSM example subsystem.

---
 rtl/fsm_cc7_pkg.sv | 24 ++
 rtl/fsm_cc7_sched_rr_arbiter.sv | 30 +++
 rtl/fsm_cc7_sched.sv | 167 ++++++++++++++++
 tb/tb_fsm_cc7_sched.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/fsm_cc7_pkg.sv
// Shared definitions for the fsm_cc7 example subsystem: scheduler states,
// drain length and the step-sequencer state codes.
package fsm_cc7_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GO    = 2'd1,
    ST_DWELL = 2'd2,
    ST_DRAIN = 2'd3
  } sched_state_e;

  // S3 -> S4 .. S9 -> S0 takes seven steps once jmp drops
  localparam int DRAIN_LEN = 7;

  typedef enum logic [3:0] {
    S0 = 4'd0, S1 = 4'd1, S2 = 4'd2, S3 = 4'd3, S4 = 4'd4,
    S5 = 4'd5, S6 = 4'd6, S7 = 4'd7, S8 = 4'd8, S9 = 4'd9
  } seq_state_e;

  function automatic int rr_index(input int base, input int off, input int n);
    return (base + off) % n;
  endfunction

endpackage

// File: rtl/fsm_cc7_sched_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after the pointer
// wins. The pointer itself is owned by the caller.
module fsm_cc7_sched_rr_arbiter
  import fsm_cc7_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int PW    = 1
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [PW-1:0]    i_ptr,
  output logic [N_REQ-1:0] o_gnt,
  output logic             o_vld
);

  logic [PW-1:0] w_idx;

  always_comb begin
    o_gnt = '0;
    o_vld = 1'b0;
    w_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_idx = PW'(rr_index(int'(i_ptr), i, N_REQ));
      if (!o_vld && i_req[w_idx]) begin
        o_gnt[w_idx] = 1'b1;
        o_vld        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fsm_cc7_sched.sv
// Round-robin scheduler sharing one fsm_cc7_2 step sequencer between
// N_REQ requesters, with y1 tracking check and sticky sync-loss flag.
//
// state    | meaning
// IDLE     | sequencer parked in S0; arbitrate
// GO       | go=1 jmp=1, sequencer S0 -> S3
// DWELL    | jmp=1, sequencer held in S3 for dcnt cycles
// DRAIN    | jmp=0, sequencer walks S3 .. S9 -> S0 (7 cycles)
module fsm_cc7_sched
  import fsm_cc7_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int DW    = 4
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [N_REQ-1:0]    i_req,
  input  logic [N_REQ*DW-1:0] i_dwell,
  input  logic                i_y1,
  output logic                o_go,
  output logic                o_jmp,
  output logic [N_REQ-1:0]    o_gnt,
  output logic [N_REQ-1:0]    o_done,
  output logic                o_busy,
  output logic                o_err
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  sched_state_e     r_state;
  sched_state_e     w_state_nxt;
  logic [PW-1:0]    r_ptr;
  logic [DW-1:0]    r_dcnt;
  logic [2:0]       r_drain_cnt;
  logic [N_REQ-1:0] r_gnt;
  logic [N_REQ-1:0] r_done;
  logic             r_err;

  logic [N_REQ-1:0] w_win;
  logic             w_win_vld;
  logic [PW-1:0]    w_win_idx;
  logic [DW-1:0]    w_win_dwell;
  logic [DW-1:0]    w_dwell_arr [N_REQ];
  logic             w_grant;
  logic             w_y1_exp;
  logic             w_y1_bad;
  logic             w_drain_last;

  fsm_cc7_sched_rr_arbiter #(
    .N_REQ (N_REQ),
    .PW    (PW)
  ) u_arb (
    .i_req (i_req),
    .i_ptr (r_ptr),
    .o_gnt (w_win),
    .o_vld (w_win_vld)
  );

  for (genvar g = 0; g < N_REQ; g++) begin : g_dwell
    assign w_dwell_arr[g] = i_dwell[g*DW +: DW];
  end

  always_comb begin
    w_win_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_win[i]) w_win_idx = PW'(i);
    end
  end

  assign w_win_dwell  = w_dwell_arr[w_win_idx];
  assign w_grant      = (r_state == ST_IDLE) && !r_err && w_win_vld;
  assign w_drain_last = (r_drain_cnt == 3'(DRAIN_LEN - 1));

  // y1 is high while the sequencer sits in S3: every DWELL cycle and the
  // first DRAIN cycle, since S3 is left one edge after jmp drops.
  always_comb begin
    w_y1_exp = 1'b0;
    unique case (r_state)
      ST_DWELL: w_y1_exp = 1'b1;
      ST_DRAIN: w_y1_exp = (r_drain_cnt == 3'd0);
      default:  w_y1_exp = 1'b0;
    endcase
  end

  assign w_y1_bad = (r_state != ST_IDLE) && (i_y1 != w_y1_exp);

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:  if (w_grant) w_state_nxt = ST_GO;
      ST_GO:    w_state_nxt = (r_dcnt != '0) ? ST_DWELL : ST_DRAIN;
      ST_DWELL: if (r_dcnt == DW'(1)) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (w_drain_last) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
    if (w_y1_bad) w_state_nxt = ST_IDLE;
  end

  always_comb begin
    o_go   = 1'b0;
    o_jmp  = 1'b0;
    o_busy = 1'b0;
    unique case (r_state)
      ST_GO: begin
        o_go   = 1'b1;
        o_jmp  = 1'b1;
        o_busy = 1'b1;
      end
      ST_DWELL: begin
        o_jmp  = 1'b1;
        o_busy = 1'b1;
      end
      ST_DRAIN: o_busy = 1'b1;
      default: begin
        o_go   = 1'b0;
        o_jmp  = 1'b0;
        o_busy = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr       <= '0;
      r_dcnt      <= '0;
      r_drain_cnt <= '0;
      r_gnt       <= '0;
      r_done      <= '0;
      r_err       <= 1'b0;
    end else begin
      r_done      <= '0;
      r_drain_cnt <= (r_state == ST_DRAIN && !w_drain_last) ? r_drain_cnt + 3'd1 : 3'd0;
      if (w_y1_bad) begin
        r_err <= 1'b1;
        r_gnt <= '0;
      end else begin
        unique case (r_state)
          ST_IDLE: begin
            if (w_grant) begin
              r_gnt  <= w_win;
              r_dcnt <= w_win_dwell;
              r_ptr  <= (w_win_idx == PW'(N_REQ - 1)) ? '0 : w_win_idx + 1'b1;
            end
          end
          ST_DWELL: r_dcnt <= r_dcnt - 1'b1;
          ST_DRAIN: begin
            if (w_drain_last) begin
              r_gnt  <= '0;
              r_done <= r_gnt;
            end
          end
          default: r_dcnt <= r_dcnt;
        endcase
      end
    end
  end

  assign o_gnt  = r_gnt;
  assign o_done = r_done;
  assign o_err  = r_err;

endmodule

// File: tb/tb_fsm_cc7_sched.sv
// Scoreboard bench for fsm_cc7_sched with a behavioural stand-in for the
// fsm_cc7_2 sequencer driving y1.
module tb_fsm_cc7_sched;

  localparam int N_REQ = 2;
  localparam int DW    = 4;
  localparam int BIG   = 32'h3fff_ffff;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [N_REQ-1:0]    req = '0;
  logic [N_REQ*DW-1:0] dwell = '0;
  logic                kill = 1'b0;
  logic                y1;
  logic                go, jmp, busy, err;
  logic [N_REQ-1:0]    gnt, done;

  int cyc = 0;
  int seq_pos = 0;
  int n_checks = 0;
  int n_errors = 0;
  bit mon_on = 1'b0;

  typedef struct {
    int win;
    int done_cyc;
  } exp_t;
  exp_t sb[$];

  // transaction-level reference model
  int m_g = 0, m_d = 0, m_win = 0, m_dw = 0, m_ptr = 0, m_free = 0;
  int m_errfrom = BIG, m_errto = BIG, m_kill_cyc = -1;
  int n_grant = 0;

  fsm_cc7_sched #(.N_REQ(N_REQ), .DW(DW)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_req   (req),
    .i_dwell (dwell),
    .i_y1    (y1),
    .o_go    (go),
    .o_jmp   (jmp),
    .o_gnt   (gnt),
    .o_done  (done),
    .o_busy  (busy),
    .o_err   (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // sequencer stand-in: S0 -(go&jmp)-> S3, hold on jmp, then S4..S9 -> S0
  always @(posedge clk) begin
    if (rst) seq_pos <= 0;
    else if (seq_pos == 0) begin
      if (go && jmp) seq_pos <= 3;
    end else if (seq_pos == 3) begin
      if (!jmp) seq_pos <= 4;
    end else if (seq_pos == 9) seq_pos <= 0;
    else if (seq_pos >= 4) seq_pos <= seq_pos + 1;
  end

  assign y1 = (seq_pos == 3) && !kill;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  task automatic tick(input logic [N_REQ-1:0] rq, input logic [N_REQ*DW-1:0] dw,
                      input bit rs, input bit flt);
    int c, win, dv, idx;
    exp_t e;
    @(posedge clk);
    #2;
    c     = cyc;
    rst   = rs;
    req   = rq;
    dwell = dw;
    kill  = (m_kill_cyc == c);
    if (rs) begin
      if (m_d > c + 1) m_d = c + 1;
      if (m_errto > c + 1) m_errto = c + 1;
      if (sb.size() > 0 && sb[$].done_cyc > c) e = sb.pop_back();
      m_ptr      = 0;
      m_free     = c + 1;
      m_kill_cyc = -1;
    end else if (c >= m_free && !(c >= m_errfrom && c < m_errto) && rq != '0) begin
      win = -1;
      for (int i = 0; i < N_REQ; i++) begin
        idx = (m_ptr + i) % N_REQ;
        if (win < 0 && ((int'(rq) >> idx) & 1) == 1) win = idx;
      end
      dv    = (int'(dw) >> (win * DW)) % (1 << DW);
      m_g   = c + 1;
      m_win = win;
      m_dw  = dv;
      m_ptr = (win + 1) % N_REQ;
      n_grant++;
      if (flt && dv >= 2) begin
        m_kill_cyc = m_g + 2;
        m_d        = m_g + 3;
        m_errfrom  = m_g + 3;
        m_errto    = BIG;
        m_free     = BIG;
      end else begin
        m_d        = m_g + dv + 8;
        e.win      = win;
        e.done_cyc = m_d;
        sb.push_back(e);
        m_free     = m_d;
      end
    end
  endtask

  initial begin
    int c;
    logic busy_e;
    logic [31:0] done_e;
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_on) begin
        c = cyc;
        busy_e = (c >= m_g) && (c < m_d);
        chk("busy", 32'(busy), 32'(busy_e));
        chk("gnt", 32'(gnt), busy_e ? (32'd1 << m_win) : 32'd0);
        chk("go", 32'(go), 32'(busy_e && c == m_g));
        chk("jmp", 32'(jmp), 32'(busy_e && c <= m_g + m_dw));
        chk("err", 32'(err), 32'(c >= m_errfrom && c < m_errto));
        done_e = 32'd0;
        if (sb.size() > 0 && sb[0].done_cyc == c) begin
          done_e = 32'd1 << sb[0].win;
          e = sb.pop_front();
        end
        chk("done", 32'(done), done_e);
      end
    end
  end

  initial begin
    int g0, k;
    tick('0, '0, 1'b1, 1'b0);
    mon_on = 1'b1;
    repeat (2) tick('0, '0, 1'b1, 1'b0);

    // dwell 3 on requester 0, req dropped and dwell scrambled mid-flight
    tick(2'b01, 8'h03, 1'b0, 1'b0);
    repeat (14) tick('0, 8'($urandom), 1'b0, 1'b0);

    // dwell 0 skips DWELL
    tick(2'b01, 8'h00, 1'b0, 1'b0);
    repeat (10) tick('0, 8'($urandom), 1'b0, 1'b0);

    // both requesting, back-to-back alternation
    repeat (45) tick(2'b11, 8'h22, 1'b0, 1'b0);

    // sync loss on the second DWELL cycle, then no further grants
    g0 = n_grant;
    k = 0;
    while (n_grant == g0 && k < 40) begin
      tick(2'b11, 8'h33, 1'b0, 1'b1);
      k++;
    end
    repeat (25) tick(2'b11, 8'h33, 1'b0, 1'b0);

    // reset clears err; then reset again in the middle of DRAIN
    tick('0, '0, 1'b1, 1'b0);
    g0 = n_grant;
    k = 0;
    while (n_grant == g0 && k < 10) begin
      tick(2'b11, 8'h12, 1'b0, 1'b0);
      k++;
    end
    k = 0;
    while (cyc + 1 < m_g + m_dw + 4 && k < 40) begin
      tick('0, 8'($urandom), 1'b0, 1'b0);
      k++;
    end
    tick('0, '0, 1'b1, 1'b0);
    repeat (20) tick(2'b10, 8'($urandom), 1'b0, 1'b0);

    // maximum dwell on requester 1
    g0 = n_grant;
    k = 0;
    while (n_grant == g0 && k < 40) begin
      tick(2'b10, 8'hF0, 1'b0, 1'b0);
      k++;
    end
    repeat (30) tick('0, 8'($urandom), 1'b0, 1'b0);

    // randomized traffic with occasional faults and resets
    repeat (3000) begin
      tick(2'($urandom_range(0, 3)), 8'($urandom),
           ($urandom_range(0, 199) == 0), ($urandom_range(0, 24) == 0));
    end
    repeat (30) tick('0, '0, 1'b0, 1'b0);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
